mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency backing memory between the IF-stage instruction fetch and the MEM-stage data access of the 5-stage MIPS_R2000 pipeline.
- Sequences each access as a request/acknowledge transaction and returns the read data.
- Generates the stall signals that freeze the pipeline while an access is outstanding.
- Applies fixed data-first priority with an anti-starvation guard for fetch, plus a watchdog timeout.

Parameters:
- AW, 32, address width (byte address).
- DW, 32, data width.
- MAX_D_BURST, 4, maximum consecutive data grants while fetch is waiting; on reaching it, fetch is granted next.
- TIMEOUT, 64, cycles in a BUSY state without mem_ack before the access is aborted; 0 disables the watchdog.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held until i_done.
- i_addr  in  AW  fetch address.
- i_rdata  out  DW  fetched instruction, valid when i_done=1.
- i_done  out  1  one-cycle fetch-complete pulse.
- if_stall  out  1  combinational: i_req & ~i_done.
- d_req  in  1  data request; held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  byte strobes, stores only.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_rdata  out  DW  load data, valid when d_done=1.
- d_done  out  1  one-cycle data-complete pulse.
- mem_stall  out  1  combinational: d_req & ~d_done.
- mem_req  out  1  backing-memory request.
- mem_we  out  1  backing-memory write enable.
- mem_be  out  4  backing-memory byte strobes.
- mem_addr  out  AW  backing-memory address.
- mem_wdata  out  DW  backing-memory write data.
- mem_ack  in  1  memory completion; rdata valid in the same cycle.
- mem_rdata  in  DW  memory read data.
- timeout_err  out  1  sticky; cleared only by rst.

Behaviour:
- Reset values: state IDLE. mem_req, mem_we, i_done, d_done, timeout_err = 0. mem_be = 0. mem_addr, mem_wdata, i_rdata, d_rdata = 0. Burst counter and watchdog counter = 0.
- FSM states: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE, grant decision:
  - d_req & (~i_req | burst < MAX_D_BURST) -> BUSY_D.
  - else i_req -> BUSY_I.
  - else stay in IDLE.
- On grant, register mem_addr/mem_we/mem_be/mem_wdata from the winner and set mem_req=1 from the next cycle. mem_we=0 and mem_be=0 for fetch.
- BUSY_x: all mem_* outputs held stable until mem_ack. Requester inputs are ignored while busy.
- On mem_ack:
  - Capture mem_rdata into i_rdata or d_rdata. d_rdata is still updated on a store, with don't-care content.
  - Pulse i_done or d_done for exactly one cycle (registered).
  - mem_req drops in that same registered update; state -> DONE.
- DONE: one cycle, no request issued; lets the requester deassert or change its request. Then -> IDLE.
- Back-to-back spacing: each transaction occupies ≥3 cycles (grant, ≥1 busy, done).
- Minimum latency: req sampled at cycle 0, mem_req high cycles 1..k, done pulse at cycle k+1.
- Output holds: i_rdata holds its value until the next fetch completion. d_rdata holds until the next data completion.
- Burst counter:
  - Increments on each data grant made while i_req=1.
  - Clears on any fetch grant, and whenever i_req=0 in IDLE.
  - Saturates at MAX_D_BURST.
- Watchdog:
  - Counts cycles in BUSY_x and resets on entry to BUSY_x.
  - On reaching TIMEOUT: drop mem_req, set timeout_err, pulse the corresponding done with rdata=0, go to DONE. The pipeline is never deadlocked.
- Simultaneous mem_ack and timeout in the same cycle: the ack wins and real data is returned.
- mem_ack in IDLE or DONE: ignored.
- rst asserted mid-transaction: next edge returns to IDLE with mem_req=0. No done pulse is produced for the aborted access.

Test Plan:
- Single fetch: i_req=1, addr=0x40, mem_ack one cycle after mem_req with rdata=0x2008000A. Required: mem_req high exactly 1 cycle, i_done at cycle 2, i_rdata=0x2008000A, if_stall high cycles 0–1.
- Store: d_req=1, d_we=1, be=4'b1111, addr=0x100, wdata=0xDEADBEEF, ack delayed 3 cycles. Required: mem_* stable 3 cycles, d_done one pulse, mem_we=0 after completion.
- Contention: i_req and d_req held continuously with MAX_D_BURST=4. Required grant order D,D,D,D,I,D,D,D,D,I.
- Timeout: TIMEOUT=8, never ack. Required: mem_req drops after 8 busy cycles, timeout_err=1 and stays sticky, d_done pulses with d_rdata=0.
- Ack coincident with the TIMEOUT cycle, rdata=0x1234. Required: done pulse with 0x1234, timeout_err stays 0.
- rst asserted while in BUSY_I. Required: next cycle state IDLE, mem_req=0, no i_done, all outputs at reset values.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and data access.
// Data has priority; fetch is guaranteed a grant after MAX_D_BURST consecutive data grants.
// A watchdog aborts accesses that never see mem_ack, so the pipeline cannot deadlock.
module mem_port_arbiter #(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned MAX_D_BURST = 4,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_done,
    output logic          if_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          mem_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          timeout_err
);

    localparam int unsigned BW      = (MAX_D_BURST > 0) ? $clog2(MAX_D_BURST + 1) : 1;
    localparam int unsigned WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned WD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [BW-1:0]   burst_cnt;
    logic [WD_W-1:0] wd_cnt;
    logic            grant_d_c, grant_i_c, ack_c, tmo_c;

    // Pipeline stalls while a request is pending and its done pulse has not arrived.
    assign if_stall  = i_req & ~i_done;
    assign mem_stall = d_req & ~d_done;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Grant decision, completion detection and next state.
    always_comb begin
        state_nxt = state;
        grant_d_c = 1'b0;
        grant_i_c = 1'b0;
        ack_c     = 1'b0;
        tmo_c     = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && (!i_req || (burst_cnt < BW'(MAX_D_BURST)))) begin
                    grant_d_c = 1'b1;
                    state_nxt = BUSY_D;
                end else if (i_req) begin
                    grant_i_c = 1'b1;
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                // A real ack in the timeout cycle takes precedence over the abort.
                if (mem_ack) begin
                    ack_c     = 1'b1;
                    state_nxt = DONE;
                end else if ((TIMEOUT != 0) && (wd_cnt == WD_W'(WD_LAST))) begin
                    tmo_c     = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory request registers, read-data capture, done pulses and watchdog/burst counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= 4'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            i_rdata     <= '0;
            d_rdata     <= '0;
            i_done      <= 1'b0;
            d_done      <= 1'b0;
            timeout_err <= 1'b0;
            burst_cnt   <= '0;
            wd_cnt      <= '0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!i_req || grant_i_c) begin
                        burst_cnt <= '0;
                    end else if (grant_d_c && (burst_cnt < BW'(MAX_D_BURST))) begin
                        burst_cnt <= burst_cnt + BW'(1);
                    end
                    if (grant_d_c) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_be    <= d_be;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        wd_cnt    <= '0;
                    end else if (grant_i_c) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_be    <= 4'b0;
                        mem_addr  <= i_addr;
                        mem_wdata <= '0;
                        wd_cnt    <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (ack_c || tmo_c) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= 4'b0;
                        if (tmo_c) timeout_err <= 1'b1;
                        if (state == BUSY_I) begin
                            i_done  <= 1'b1;
                            i_rdata <= ack_c ? mem_rdata : '0;
                        end else begin
                            d_done  <= 1'b1;
                            d_rdata <= ack_c ? mem_rdata : '0;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-phase reference model.
module tb_mem_port_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXB = 4;
    localparam int unsigned TMO  = 8;

    logic          clk;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_done;
    logic          if_stall;
    logic          d_req;
    logic          d_we;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          mem_stall;
    logic          mem_req;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          timeout_err;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MAX_D_BURST(MAXB), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .mem_stall(mem_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0 = free, 1 = access outstanding, 2 = completion cycle.
    int          phase;
    int unsigned bcnt;
    int unsigned lat;
    int unsigned dcount;
    bit          win_d;
    bit          e_req, e_idone, e_ddone, e_terr, e_we, dknown, prev_req;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;
    byte         gq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        phase    = 0;
        bcnt     = 0;
        lat      = 1;
        dcount   = 0;
        win_d    = 1'b0;
        e_req    = 1'b0;
        e_idone  = 1'b0;
        e_ddone  = 1'b0;
        e_terr   = 1'b0;
        e_we     = 1'b0;
        e_be     = 4'b0;
        e_addr   = '0;
        e_wdata  = '0;
        e_irdata = '0;
        e_drdata = '0;
        dknown   = 1'b1;
        prev_req = 1'b0;
    endtask

    // Called at a negedge: check this cycle's outputs, drive this cycle's inputs, advance the model.
    task automatic run_cycles(input int n, input int unsigned max_lat,
                              input int unsigned ipct, input int unsigned dpct);
        for (int c = 0; c < n; c++) begin
            logic [31:0] rd;
            bit          gd;
            bit          fin;

            check("mem_req", 32'(mem_req), 32'(e_req));
            if (e_req) begin
                check("mem_addr", mem_addr, e_addr);
                check("mem_we", 32'(mem_we), 32'(e_we));
                check("mem_be", 32'(mem_be), 32'(e_be));
                if (e_we) check("mem_wdata", mem_wdata, e_wdata);
            end else begin
                check("mem_we_idle", 32'(mem_we), 32'd0);
            end
            check("i_done", 32'(i_done), 32'(e_idone));
            check("d_done", 32'(d_done), 32'(e_ddone));
            check("timeout_err", 32'(timeout_err), 32'(e_terr));
            check("i_rdata", i_rdata, e_irdata);
            if (dknown) check("d_rdata", d_rdata, e_drdata);
            check("if_stall", 32'(if_stall), 32'(i_req & ~e_idone));
            check("mem_stall", 32'(mem_stall), 32'(d_req & ~e_ddone));

            if (mem_req && !prev_req) gq.push_back(mem_addr[31] ? 8'h44 : 8'h49);
            prev_req = mem_req;

            // Requesters hold until done, then may issue a new request immediately.
            if (e_idone || !i_req) begin
                if ($urandom_range(0, 99) < ipct) begin
                    i_req  = 1'b1;
                    i_addr = $urandom & 32'h7FFF_FFFC;
                end else begin
                    i_req = 1'b0;
                end
            end
            if (e_ddone || !d_req) begin
                if ($urandom_range(0, 99) < dpct) begin
                    d_req   = 1'b1;
                    d_we    = 1'($urandom_range(0, 1));
                    d_be    = 4'($urandom_range(1, 15));
                    d_addr  = ($urandom | 32'h8000_0000) & 32'hFFFF_FFFC;
                    d_wdata = $urandom;
                end else begin
                    d_req = 1'b0;
                end
            end

            // Backing memory: ack after the chosen latency; stray acks while not busy.
            mem_rdata = $urandom;
            if (phase == 1) mem_ack = (bcnt + 1 == lat);
            else            mem_ack = ($urandom_range(0, 3) == 0);

            e_idone = 1'b0;
            e_ddone = 1'b0;
            case (phase)
                0: begin
                    gd = d_req && (!i_req || dcount < MAXB);
                    if (!i_req) dcount = 0;
                    if (gd) begin
                        if (i_req && dcount < MAXB) dcount++;
                        win_d   = 1'b1;
                        e_addr  = d_addr;
                        e_we    = d_we;
                        e_be    = d_be;
                        e_wdata = d_wdata;
                    end else if (i_req) begin
                        dcount = 0;
                        win_d  = 1'b0;
                        e_addr = i_addr;
                        e_we   = 1'b0;
                        e_be   = 4'b0;
                    end
                    if (gd || i_req) begin
                        phase = 1;
                        bcnt  = 0;
                        lat   = $urandom_range(1, max_lat);
                    end
                end
                1: begin
                    fin = 1'b0;
                    rd  = '0;
                    if (mem_ack) begin
                        fin = 1'b1;
                        rd  = mem_rdata;
                    end else if (bcnt + 1 == TMO) begin
                        fin    = 1'b1;
                        e_terr = 1'b1;
                    end else begin
                        bcnt++;
                    end
                    if (fin) begin
                        phase = 2;
                        if (win_d) begin
                            e_ddone = 1'b1;
                            if (e_we && mem_ack) dknown = 1'b0;
                            else begin
                                dknown   = 1'b1;
                                e_drdata = rd;
                            end
                        end else begin
                            e_idone  = 1'b1;
                            e_irdata = rd;
                        end
                    end
                end
                default: phase = 0;
            endcase
            e_req = (phase == 1);

            @(negedge clk);
        end
    endtask

    initial begin
        string exp_order;
        bit    found;

        rst       = 1'b1;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_be      = 4'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Continuous contention from a clean reset: fixed grant order.
        run_cycles(70, 3, 100, 100);
        exp_order = "DDDDIDDDDI";
        for (int i = 0; i < 10; i++) begin
            byte g;
            g = (i < gq.size()) ? gq[i] : 8'h3F;
            check("grant_order", 32'(g), 32'(exp_order[i]));
        end

        // Mixed traffic with latency up to the watchdog limit (ack may coincide with it).
        run_cycles(400, TMO, 50, 50);
        // Latencies past the limit trigger aborts; timeout_err must stay sticky.
        run_cycles(400, TMO + 4, 60, 60);

        // Reset in the first cycle of a fetch access.
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            run_cycles(1, TMO, 100, 0);
            found = (phase == 1) && (bcnt == 0) && !win_d;
        end
        check("reach_busy_i", 32'(found), 32'd1);
        check("busy_i_req", 32'(mem_req), 32'd1);
        rst     = 1'b1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_i_done", 32'(i_done), 32'd0);
        check("rst_d_done", 32'(d_done), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        rst = 1'b0;
        model_reset();

        run_cycles(200, TMO, 50, 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
